// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: writeback arbiter in front of the register file write port.
// The ALU result has priority and is written one cycle after it is presented.
// Mult/div results queue in a small FIFO and drain on cycles when the ALU is not writing.
// An ALU write to register R kills every queued mult/div entry that also targets R,
// so an older mult/div result can never overwrite a newer ALU result.
// Optional feature macro: WB_PENDING_EN adds md_pending, one bit per register
// that still has a live queued mult/div write.
//
// Mult/div handshake: a result transfers on a posedge where md_valid && md_ready.
// md_ready depends only on the registered occupancy, never on md_valid, and it is
// low while reset is asserted. A transfer with md_rd == 0 completes without enqueuing.
module regfile_wb_arbiter #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                     clock,
    input  logic                     ctrl_reset_n,
    input  logic                     alu_valid,
    input  logic [ADDR_W-1:0]        alu_rd,
    input  logic [DATA_W-1:0]        alu_data,
    input  logic                     md_valid,
    output logic                     md_ready,
    input  logic [ADDR_W-1:0]        md_rd,
    input  logic [DATA_W-1:0]        md_data,
    output logic                     wb_writeEn,
    output logic [ADDR_W-1:0]        wb_writeReg,
    output logic [DATA_W-1:0]        wb_data,
`ifdef WB_PENDING_EN
    output logic [2**ADDR_W-1:0]     md_pending,
`endif
    output logic [$clog2(DEPTH):0]   md_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] rdQ   [DEPTH];
    logic [DATA_W-1:0] dataQ [DEPTH];
    logic [DEPTH-1:0]  liveQ;
    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;
    logic [CNT_W-1:0]  mdCount;

    logic aluWrite;
    logic mdPush;
    logic doPop;
    logic pushLive;

    // Ready from registered occupancy only; forced low while reset is held.
    always_comb begin
        md_ready = ctrl_reset_n && (mdCount != FULL_COUNT);
    end

    // Per-cycle decisions: ALU write wins, FIFO drains only on ALU-free cycles.
    always_comb begin
        aluWrite = alu_valid && (alu_rd != '0);
        mdPush   = md_valid && md_ready && (md_rd != '0);
        doPop    = !aluWrite && (mdCount != '0);
        // Same-cycle ALU write to the same register is treated as newer.
        pushLive = !(aluWrite && (md_rd == alu_rd));
    end

    // FIFO storage, pointers, occupancy and per-entry live bits.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            wrPtr   <= '0;
            rdPtr   <= '0;
            mdCount <= '0;
            liveQ   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rdQ[i]   <= '0;
                dataQ[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (aluWrite && (rdQ[i] == alu_rd)) begin
                    liveQ[i] <= 1'b0;
                end
            end
            if (doPop) begin
                liveQ[rdPtr] <= 1'b0;
                rdPtr        <= rdPtr + PTR_W'(1);
            end
            // The push slot never equals the head slot while popping (0 < count < DEPTH).
            if (mdPush) begin
                rdQ[wrPtr]   <= md_rd;
                dataQ[wrPtr] <= md_data;
                liveQ[wrPtr] <= pushLive;
                wrPtr        <= wrPtr + PTR_W'(1);
            end
            if (mdPush && !doPop) begin
                mdCount <= mdCount + CNT_W'(1);
            end else if (!mdPush && doPop) begin
                mdCount <= mdCount - CNT_W'(1);
            end
        end
    end

    // Registered regfile write port: ALU first, then a live FIFO head, else idle with hold.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            wb_writeEn  <= 1'b0;
            wb_writeReg <= '0;
            wb_data     <= '0;
        end else if (aluWrite) begin
            wb_writeEn  <= 1'b1;
            wb_writeReg <= alu_rd;
            wb_data     <= alu_data;
        end else if (doPop && liveQ[rdPtr]) begin
            wb_writeEn  <= 1'b1;
            wb_writeReg <= rdQ[rdPtr];
            wb_data     <= dataQ[rdPtr];
        end else begin
            wb_writeEn  <= 1'b0;
        end
    end

    assign md_count = mdCount;

`ifdef WB_PENDING_EN
    // One bit per register with a live queued write; popped entries are already not live.
    always_comb begin
        md_pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (liveQ[i]) begin
                md_pending[rdQ[i]] = 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Writeback stage directly upstream of the register file; sole driver of the regfile write port (write enable, write register, write data).
- Merges two result sources: the single-cycle ALU path (no backpressure, priority) and the multi-cycle mult/div unit (valid/ready handshake, buffered in a small FIFO).
- Guarantees one regfile write per cycle, suppresses writes to $r0, and never lets a stale mult/div result overwrite a newer ALU result.

Parameters:
DEPTH, 4, mult/div FIFO entries (power of 2, >=2)
DATA_W, 32, result/data width
ADDR_W, 5, register index width

Ports:
clock  input  1  system clock, all state on posedge
ctrl_reset_n  input  1  asynchronous active-low reset
alu_valid  input  1  ALU result present this cycle (always accepted)
alu_rd  input  ADDR_W  ALU destination register
alu_data  input  DATA_W  ALU result
md_valid  input  1  mult/div result offered
md_ready  output  1  arbiter can accept mult/div result
md_rd  input  ADDR_W  mult/div destination register
md_data  input  DATA_W  mult/div result
wb_writeEn  output  1  to regfile write enable (registered)
wb_writeReg  output  ADDR_W  to regfile write register (registered)
wb_data  output  DATA_W  to regfile write data (registered)
md_count  output  clog2(DEPTH)+1  FIFO occupancy, killed entries included

Behaviour:
- Reset (async, ctrl_reset_n low): wb_writeEn=0, wb_writeReg=0, wb_data=0, md_count=0, all entry-valid bits cleared, pointers 0; md_ready=0 while reset asserted.
- md_ready = (md_count != DEPTH) when out of reset; combinational from registered count only. No push-through-when-full.
- Handshake: mult/div transfer occurs on posedge where md_valid && md_ready. md_rd==0 transfers complete but nothing is enqueued.
- ALU path: alu_valid && alu_rd!=0 -> next posedge wb_writeEn=1, wb_writeReg=alu_rd, wb_data=alu_data (latency 1). alu_rd==0 -> no write.
- Pop: when no ALU write is being issued this cycle and FIFO non-empty, head is popped. Live head -> wb_* driven with head rd/data next posedge. Killed head -> popped, wb_writeEn=0 that cycle.
- Mult/div latency: min 2 cycles from handshake to wb_writeEn (no bypass of empty FIFO).
- Staleness kill: accepted ALU write with rd=R clears the valid bit of every queued entry with rd=R. A mult/div entry pushed in the same cycle as an ALU write to the same R enters killed (ALU treated as newer).
- Simultaneous push and pop: both occur; md_count unchanged.
- Wrap-around: pointers are clog2(DEPTH) bits, wrap modulo DEPTH; full/empty from md_count.
- Idle cycle (no ALU write, FIFO empty): wb_writeEn=0; wb_writeReg/wb_data hold previous values.
- Reset mid-operation: all queued entries discarded, no write issued after reset edge.

Optional Feature:
WB_PENDING_EN
- Defined: extra output md_pending [2**ADDR_W-1:0], bit R set iff a live (unkilled) FIFO entry targets R; combinational from entry state; for decode-stage stall logic.
- Undefined: port absent, no pending logic synthesized; all other behaviour identical.

Test Plan:
- Reset asserted 2 cycles, then release -> all wb_* 0, md_count=0, md_ready=1 on first cycle after release.
- alu_valid, rd=5, data=32'h0000DEAD -> next posedge wb_writeEn=1, wb_writeReg=5, wb_data=32'h0000DEAD; alu rd=0 -> wb_writeEn=0.
- md push rd=7 data=32'h12345678 with continuous ALU writes to rd=3 for 3 cycles -> md_count=1 throughout, rd=7 written on first ALU-free cycle, then md_count=0.
- 4 md pushes (rd=1..4) while ALU busy -> md_count=4, md_ready=0, 5th md_valid stalls; after ALU stops, writes drain in order rd=1,2,3,4 on consecutive cycles.
- md push rd=9 data=32'hAAAA0000 queued, then ALU write rd=9 data=32'h0000BEEF -> only 32'h0000BEEF reaches r9; killed pop produces a cycle with wb_writeEn=0.
- Reset asserted with 3 entries queued -> md_count=0 immediately, no wb_writeEn pulse after release; with WB_PENDING_EN, md_pending=0.
